// File: rtl/led_pkg.sv
// Shared definitions for the LED step controller and the pattern sequencer.
package led_pkg;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_PAUSE = 1'b1
    } state_t;

    localparam int SPEED_W            = 2;
    localparam int DIV_W              = 24;
    localparam int DIV_BASE_DEFAULT   = 12_500_000;
    localparam int DEB_CYCLES_DEFAULT = 1_000_000;

endpackage

// File: rtl/btn_debounce.sv
// Raw button conditioning: 2-FF synchroniser, debounce counter, and a
// one-cycle pulse on each accepted 0->1 transition of the debounced level.
module btn_debounce #(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);

    localparam int               CNT_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             level_prev_q, level_prev_d;
    logic             press_q, press_d;

    // The counter tracks how long the synchronised sample has disagreed with
    // the accepted level; any agreeing sample restarts the qualification.
    always_comb begin
        sync1_d      = btn_raw;
        sync2_d      = sync1_q;
        level_d      = level_q;
        cnt_d        = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        level_prev_d = level_q;
        press_d      = level_q & ~level_prev_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            cnt_q        <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            press_q      <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_prev_d;
            press_q      <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/led_step_ctrl.sv
// Step-rate controller: debounced speed/pause buttons, run/pause FSM and a
// programmable divider producing a one-cycle step enable for the sequencer.
module led_step_ctrl #(
    parameter int DIV_BASE   = led_pkg::DIV_BASE_DEFAULT,
    parameter int DEB_CYCLES = led_pkg::DEB_CYCLES_DEFAULT,
    parameter int DIV_W      = led_pkg::DIV_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        btn_speed,
    input  logic                        btn_pause,
    output logic                        step,
    output logic [led_pkg::SPEED_W-1:0] speed,
    output logic                        running
);

    localparam int               SPEED_W = led_pkg::SPEED_W;
    localparam logic [DIV_W-1:0] BASE    = DIV_W'(DIV_BASE);

    logic speed_press;
    logic pause_press;

    logic [SPEED_W-1:0] speed_q, speed_d;
    led_pkg::state_t    state_q, state_d;
    logic [DIV_W-1:0]   count_q, count_d;
    logic               step_q, step_d;
    logic [DIV_W-1:0]   period_last;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_speed_deb (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_speed),
        .press   (speed_press)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_pause_deb (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_pause),
        .press   (pause_press)
    );

    assign period_last = (BASE >> speed_q) - DIV_W'(1);

    // A speed press restarts the divider so the new rate starts cleanly,
    // and it takes priority over the terminal-count strobe.
    always_comb begin
        speed_d = speed_q;
        state_d = state_q;
        count_d = count_q;
        step_d  = 1'b0;
        if (pause_press) begin
            if (state_q == led_pkg::ST_RUN) begin
                state_d = led_pkg::ST_PAUSE;
            end else begin
                state_d = led_pkg::ST_RUN;
            end
        end
        if (speed_press) begin
            speed_d = speed_q + SPEED_W'(1);
            count_d = '0;
        end else if (state_q == led_pkg::ST_RUN) begin
            if (count_q == period_last) begin
                count_d = '0;
                step_d  = 1'b1;
            end else begin
                count_d = count_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            speed_q <= '0;
            state_q <= led_pkg::ST_RUN;
            count_q <= '0;
            step_q  <= 1'b0;
        end else begin
            speed_q <= speed_d;
            state_q <= state_d;
            count_q <= count_d;
            step_q  <= step_d;
        end
    end

    assign step    = step_q;
    assign speed   = speed_q;
    assign running = (state_q == led_pkg::ST_RUN);

endmodule

// File: tb/tb_led_step_ctrl.sv
// Directed bench for led_step_ctrl with DIV_BASE=16, DEB_CYCLES=4.
module tb_led_step_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_speed;
    logic       btn_pause;
    logic       step;
    logic [1:0] speed;
    logic       running;

    int checks = 0;
    int errors = 0;

    int   rel_hold;
    logic rel_spd;
    logic rel_pse;

    int exp_per[4] = '{8, 4, 2, 16};
    int exp_spd[4] = '{1, 2, 3, 0};

    led_step_ctrl #(
        .DIV_BASE   (16),
        .DEB_CYCLES (4),
        .DIV_W      (24)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_speed (btn_speed),
        .btn_pause (btn_pause),
        .step      (step),
        .speed     (speed),
        .running   (running)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
        $display("check %-22s observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(posedge clk);
        @(negedge clk);
    endtask

    // Raise the selected buttons now (at a falling edge) and drop them after
    // 'hold' rising edges, in the background.
    task press(input logic s, input logic p, input int hold);
        rel_hold = hold;
        rel_spd  = s;
        rel_pse  = p;
        if (s) btn_speed = 1'b1;
        if (p) btn_pause = 1'b1;
        fork
            begin
                repeat (rel_hold) @(posedge clk);
                @(negedge clk);
                if (rel_spd) btn_speed = 1'b0;
                if (rel_pse) btn_pause = 1'b0;
            end
        join_none
    endtask

    task automatic wait_step(input int max_cyc, output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (step !== 1'b1 && n <= max_cyc);
    endtask

    task automatic wait_speed(input logic [1:0] old, input int max_cyc, output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (speed === old && n <= max_cyc);
    endtask

    task automatic wait_run(input logic want, input int max_cyc, output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (running !== want && n <= max_cyc);
    endtask

    task automatic watch(input int cycles, output int hits, output int lows);
        hits = 0;
        lows = 0;
        repeat (cycles) begin
            @(posedge clk);
            @(negedge clk);
            if (step === 1'b1) hits++;
            if (running !== 1'b1) lows++;
        end
    endtask

    initial begin
        int n;
        int hits;
        int lows;

        rst       = 1'b1;
        btn_speed = 1'b0;
        btn_pause = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_step", step, 0);
        chk("rst_speed", speed, 0);
        chk("rst_running", running, 1);

        // 1: free-running at speed 0
        rst = 1'b0;
        wait_step(40, n); chk("t1_first_step", n, 16);
        wait_step(40, n); chk("t1_period_a", n, 16);
        wait_step(40, n); chk("t1_period_b", n, 16);
        chk("t1_speed", speed, 0);
        chk("t1_running", running, 1);

        // 2: four speed presses, wrapping 3 -> 0
        for (int i = 0; i < 4; i++) begin
            idle(10);
            press(1'b1, 1'b0, 10);
            wait_speed(speed, 40, n);
            chk($sformatf("t2_press_lat_%0d", i), n, 8);
            chk($sformatf("t2_speed_%0d", i), speed, exp_spd[i]);
            wait_step(40, n);
            chk($sformatf("t2_first_step_%0d", i), n, exp_per[i]);
            wait_step(40, n);
            chk($sformatf("t2_period_%0d", i), n, exp_per[i]);
        end

        // 3: short pause glitch ignored, 6-cycle press accepted
        idle(10);
        press(1'b0, 1'b1, 3);
        watch(30, hits, lows);
        chk("t3_glitch_lows", lows, 0);
        press(1'b0, 1'b1, 6);
        wait_run(1'b0, 40, n);
        chk("t3_pause_lat", n, 8);

        // 4: pause with count held at 5, resume continues from there
        idle(20);
        press(1'b0, 1'b1, 6);
        wait_run(1'b1, 40, n);
        chk("t4_resume_lat", n, 8);
        wait_step(40, n);
        chk("t4_resync_bound", n <= 16, 1);
        idle(13);
        press(1'b0, 1'b1, 6);
        wait_run(1'b0, 40, n);
        chk("t4_pause_lat", n, 8);
        watch(100, hits, lows);
        chk("t4_paused_steps", hits, 0);
        chk("t4_paused_lows", lows, 100);
        press(1'b0, 1'b1, 6);
        wait_run(1'b1, 40, n);
        chk("t4_resume2_lat", n, 8);
        wait_step(40, n);
        chk("t4_resume_step", n, 11);

        // 5: simultaneous presses at speed 3
        for (int i = 1; i <= 3; i++) begin
            idle(10);
            press(1'b1, 1'b0, 10);
            wait_speed(speed, 40, n);
            chk($sformatf("t5_setup_lat_%0d", i), n, 8);
            chk($sformatf("t5_setup_speed_%0d", i), speed, i);
        end
        idle(20);
        chk("t5_pre_running", running, 1);
        press(1'b1, 1'b1, 6);
        wait_speed(2'd3, 40, n);
        chk("t5_both_lat", n, 8);
        chk("t5_both_speed", speed, 0);
        chk("t5_both_running", running, 0);
        chk("t5_both_step", step, 0);
        watch(40, hits, lows);
        chk("t5_paused_steps", hits, 0);
        press(1'b0, 1'b1, 6);
        wait_run(1'b1, 40, n);
        chk("t5_resume_lat", n, 8);
        wait_step(40, n);
        chk("t5_resume_step", n, 16);

        // 6: asynchronous reset mid-operation at speed 2
        for (int i = 1; i <= 2; i++) begin
            idle(10);
            press(1'b1, 1'b0, 10);
            wait_speed(speed, 40, n);
            chk($sformatf("t6_setup_speed_%0d", i), speed, i);
        end
        wait_step(40, n);
        chk("t6_pre_step", n, 4);
        #2 rst = 1'b1;
        #1;
        chk("t6_async_step", step, 0);
        chk("t6_async_speed", speed, 0);
        chk("t6_async_running", running, 1);
        idle(2);
        rst = 1'b0;
        wait_step(40, n); chk("t6_post_first", n, 16);
        wait_step(40, n); chk("t6_post_period", n, 16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
